// File: rtl/pq_pkg.sv
// Shared types and defaults for the QuickQ host port and the control-node chain.
package pq_pkg;
  localparam int PQ_DATA_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_CLEAR} host_state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_CLR} pq_op_t;
endpackage

// File: rtl/pq_return_pipe.sv
// Tracks outstanding chain reads; strobe fires RD_LAT cycles after push_i.
module pq_return_pipe #(
  parameter int RD_LAT = 3
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic push_i,
  input  logic kill_i,
  output logic strobe_o
);
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

  // kill also blocks the token being pushed in the same cycle
  always_comb begin
    vld_pipe_d = '0;
    if (!kill_i) begin
      vld_pipe_d[0] = push_i;
      for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) vld_pipe_q <= '0;
    else           vld_pipe_q <= vld_pipe_d;
  end

  assign strobe_o = vld_pipe_q[RD_LAT-1];
endmodule

// File: rtl/pq_host_port.sv
// Host-side initiator for the QuickQ node chain: arbitrates enq/deq/clear,
// enforces the command issue gap, tracks occupancy and captures read returns.
module pq_host_port
  import pq_pkg::*;
#(
  parameter int DATA_W    = PQ_DATA_W,
  parameter int DEPTH     = 64,
  parameter int ISSUE_GAP = 2,
  parameter int RD_LAT    = 3
) (
  input  logic                       clk,
  input  logic                       reset_ni,
  input  logic                       enq_valid_i,
  input  logic [DATA_W-1:0]          enq_data_i,
  output logic                       enq_ready_o,
  input  logic                       deq_req_i,
  output logic                       deq_ready_o,
  input  logic                       clear_i,
  output logic                       deq_valid_o,
  output logic [DATA_W-1:0]          deq_data_o,
  output logic                       write_o,
  output logic                       read_o,
  output logic                       reset_o,
  output logic [DATA_W-1:0]          wr_data_o,
  input  logic [DATA_W-1:0]          rd_data_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  host_state_t       state_q, state_d;
  pq_op_t            op;
  logic [GW-1:0]     gap_q, gap_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              write_q, write_d, read_q, read_d, reset_q, reset_d;
  logic              tie_enq_q, tie_enq_d;
  logic              run_q;
  logic              can_issue, enq_elig, deq_elig, tie, rd_strobe;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // run_q keeps the ready outputs low until the first edge after reset
  assign can_issue   = run_q && (state_q == ST_IDLE) && !clear_i;
  assign enq_elig    = can_issue && enq_valid_i && !full_o;
  assign deq_elig    = can_issue && deq_req_i && !empty_o;
  assign tie         = enq_elig && deq_elig;
  assign enq_ready_o = can_issue && !full_o  && !(tie && !tie_enq_q);
  assign deq_ready_o = can_issue && !empty_o && !(tie && tie_enq_q);

  always_comb begin
    op = OP_NONE;
    if (clear_i && state_q != ST_CLEAR)  op = OP_CLR;
    else if (enq_valid_i && enq_ready_o) op = OP_ENQ;
    else if (deq_req_i && deq_ready_o)   op = OP_DEQ;
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    count_d   = count_q;
    wr_data_d = wr_data_q;
    tie_enq_d = tie_enq_q;
    write_d   = 1'b0;
    read_d    = 1'b0;
    reset_d   = 1'b0;

    case (state_q)
      ST_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        state_d = (ISSUE_GAP > 1) ? ST_GAP : ST_IDLE;
        gap_d   = GW'(ISSUE_GAP - 1);
      end
      default: ;
    endcase

    case (op)
      OP_ENQ, OP_DEQ: begin
        state_d = (ISSUE_GAP > 1) ? ST_GAP : ST_IDLE;
        gap_d   = GW'(ISSUE_GAP - 1);
        if (tie) tie_enq_d = (op == OP_DEQ);
        if (op == OP_ENQ) begin
          write_d   = 1'b1;
          wr_data_d = enq_data_i;
          count_d   = count_q + CW'(1);
        end else begin
          read_d  = 1'b1;
          count_d = count_q - CW'(1);
        end
      end
      OP_CLR: begin
        state_d = ST_CLEAR;
        reset_d = 1'b1;
        count_d = '0;
        gap_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      count_q   <= '0;
      wr_data_q <= '0;
      tie_enq_q <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      reset_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      count_q   <= count_d;
      wr_data_q <= wr_data_d;
      tie_enq_q <= tie_enq_d;
      write_q   <= write_d;
      read_q    <= read_d;
      reset_q   <= reset_d;
      run_q     <= 1'b1;
    end
  end

  assign write_o   = write_q;
  assign read_o    = read_q;
  assign reset_o   = reset_q;
  assign wr_data_o = wr_data_q;

  pq_return_pipe #(.RD_LAT(RD_LAT)) u_ret (
    .clk      (clk),
    .reset_ni (reset_ni),
    .push_i   (read_q),
    .kill_i   (op == OP_CLR),
    .strobe_o (rd_strobe)
  );

  assign deq_valid_o = rd_strobe;
  assign deq_data_o  = rd_strobe ? rd_data_i : '0;

  a_count_le_depth: assert property (@(posedge clk) disable iff (!reset_ni)
    count_q <= CW'(DEPTH));
endmodule

// File: tb/tb_pq_host_port.sv
// Bench for pq_host_port: a priority-queue model plays the node chain and
// scores occupancy, command spacing and dequeue returns every cycle.
module tb_pq_host_port;
  localparam int DATA_W = 16, DEPTH = 64, ISSUE_GAP = 2, RD_LAT = 3;
  localparam int CW = $clog2(DEPTH + 1);

  logic              clk = 1'b0, reset_ni = 1'b0;
  logic              enq_valid_i = 1'b0, deq_req_i = 1'b0, clear_i = 1'b0;
  logic [DATA_W-1:0] enq_data_i = '0, rd_data_i = '0;
  logic              enq_ready_o, deq_ready_o, deq_valid_o;
  logic              write_o, read_o, reset_o, full_o, empty_o;
  logic [DATA_W-1:0] deq_data_o, wr_data_o;
  logic [CW-1:0]     count_o;

  pq_host_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ISSUE_GAP(ISSUE_GAP), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_ni(reset_ni), .enq_valid_i(enq_valid_i), .enq_data_i(enq_data_i),
    .enq_ready_o(enq_ready_o), .deq_req_i(deq_req_i), .deq_ready_o(deq_ready_o),
    .clear_i(clear_i), .deq_valid_o(deq_valid_o), .deq_data_o(deq_data_o),
    .write_o(write_o), .read_o(read_o), .reset_o(reset_o), .wr_data_o(wr_data_o),
    .rd_data_i(rd_data_i), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [DATA_W-1:0] key; } ret_t;
  logic [DATA_W-1:0] mdl[$];
  ret_t              ret_q[$];
  int                n_checks = 0, n_fail = 0;
  int                last_issue = -100;

  function automatic logic [DATA_W-1:0] pop_max();
    int bi = 0;
    logic [DATA_W-1:0] k;
    for (int i = 1; i < mdl.size(); i++) if (mdl[i] > mdl[bi]) bi = i;
    k = mdl[bi];
    mdl.delete(bi);
    return k;
  endfunction

  // Chain model + per-cycle scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    ret_t r;
    logic exp_v;
    if (!reset_ni) begin
      mdl.delete();
      ret_q.delete();
    end else begin
      if (reset_o) begin
        mdl.delete();
        ret_q.delete();
      end
      n_checks++;
      if (write_o && read_o) begin
        n_fail++; $display("FAIL both_cmds cyc=%0d write_o=1 read_o=1 required not both", cyc);
      end
      if (write_o || read_o) begin
        n_checks++;
        if (cyc - last_issue < ISSUE_GAP) begin
          n_fail++; $display("FAIL issue_gap cyc=%0d spacing=%0d required>=%0d", cyc, cyc - last_issue, ISSUE_GAP);
        end
        last_issue = cyc;
      end
      if (write_o) mdl.push_back(wr_data_o);
      if (read_o) begin
        n_checks++;
        if (mdl.size() == 0) begin
          n_fail++; $display("FAIL read_empty cyc=%0d read_o=1 with model size 0", cyc);
        end else begin
          r.due = cyc + RD_LAT;
          r.key = pop_max();
          ret_q.push_back(r);
        end
      end
      exp_v = (ret_q.size() > 0) && (ret_q[0].due == cyc);
      n_checks++;
      if (deq_valid_o !== exp_v) begin
        n_fail++; $display("FAIL deq_valid cyc=%0d got=%b required=%b", cyc, deq_valid_o, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (deq_data_o !== ret_q[0].key) begin
          n_fail++; $display("FAIL deq_data cyc=%0d got=%0d required=%0d", cyc, deq_data_o, ret_q[0].key);
        end
        void'(ret_q.pop_front());
      end
      n_checks++;
      if (count_o !== CW'(mdl.size()) || empty_o !== (mdl.size() == 0) || full_o !== (mdl.size() == DEPTH)) begin
        n_fail++; $display("FAIL occupancy cyc=%0d count=%0d empty=%b full=%b required count=%0d",
                           cyc, count_o, empty_o, full_o, mdl.size());
      end
    end
  end

  // Chain return data: the scheduled key in its due cycle, noise otherwise
  initial forever begin
    logic [DATA_W-1:0] v;
    @(posedge clk); #1;
    v = DATA_W'($urandom);
    foreach (ret_q[i]) if (ret_q[i].due == cyc) v = ret_q[i].key;
    rd_data_i = v;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    enq_valid_i = 1'b1; enq_data_i = 16'h1234;
    repeat (3) step();
    #2 reset_ni = 1'b0;
    #1;
    n_checks++;
    if ({write_o, read_o, reset_o, deq_valid_o, enq_ready_o, deq_ready_o, full_o} !== 7'b0 ||
        count_o !== '0 || empty_o !== 1'b1 || wr_data_o !== '0 || deq_data_o !== '0) begin
      n_fail++; $display("FAIL reset_outputs got wr=%b rd=%b rst=%b dv=%b er=%b dr=%b full=%b cnt=%0d empty=%b required all 0, empty=1",
                         write_o, read_o, reset_o, deq_valid_o, enq_ready_o, deq_ready_o, full_o, count_o, empty_o);
    end
    enq_valid_i = 1'b0;
    step(); step();
    reset_ni = 1'b1;
    step(); #1;
    n_checks++;
    if (enq_ready_o !== 1'b1 || count_o !== '0) begin
      n_fail++; $display("FAIL reset_release enq_ready=%b count=%0d required enq_ready=1 count=0", enq_ready_o, count_o);
    end
  endtask

  task automatic test_enq_b2b();
    logic [DATA_W-1:0] keys[3];
    int                wc[$];
    logic [DATA_W-1:0] wd[$];
    int                idx = 0;
    keys[0] = 16'd5; keys[1] = 16'd9; keys[2] = 16'd2;
    for (int n = 0; n < 30 && wc.size() < 3; n++) begin
      enq_valid_i = (idx < 3);
      if (idx < 3) enq_data_i = keys[idx];
      #1;
      if (write_o) begin wc.push_back(cyc); wd.push_back(wr_data_o); end
      if (enq_valid_i && enq_ready_o) idx++;
      step();
    end
    enq_valid_i = 1'b0;
    n_checks++;
    if (wc.size() != 3) begin
      n_fail++; $display("FAIL enq_writes got=%0d pulses required=3", wc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wd[i] !== keys[i]) begin
          n_fail++; $display("FAIL enq_wr_data[%0d] got=%0d required=%0d", i, wd[i], keys[i]);
        end
        if (i > 0) begin
          n_checks++;
          if (wc[i] - wc[i-1] != ISSUE_GAP) begin
            n_fail++; $display("FAIL enq_spacing[%0d] got=%0d required=%0d", i, wc[i] - wc[i-1], ISSUE_GAP);
          end
        end
      end
    end
    n_checks++;
    if (count_o !== CW'(3)) begin
      n_fail++; $display("FAIL enq_count got=%0d required=3", count_o);
    end
  endtask

  task automatic test_deq();
    int rc = -1, vc = -1;
    logic [DATA_W-1:0] vd = '0;
    logic got;
    deq_req_i = 1'b1;
    for (int n = 0; n < 30 && vc < 0; n++) begin
      #1;
      if (read_o && rc < 0) rc = cyc;
      if (deq_valid_o && vc < 0) begin vc = cyc; vd = deq_data_o; end
      got = deq_req_i && deq_ready_o;
      step();
      if (got) deq_req_i = 1'b0;
    end
    n_checks++;
    if (rc < 0 || vc - rc != RD_LAT) begin
      n_fail++; $display("FAIL deq_latency got=%0d required=%0d", vc - rc, RD_LAT);
    end
    n_checks++;
    if (vd !== 16'd9) begin
      n_fail++; $display("FAIL deq_key got=%0d required=9", vd);
    end
    n_checks++;
    if (count_o !== CW'(2)) begin
      n_fail++; $display("FAIL deq_count got=%0d required=2", count_o);
    end
  endtask

  task automatic test_full();
    logic got = 1'b0, bad = 1'b0;
    enq_valid_i = 1'b1;
    for (int n = 0; n < 400 && count_o < CW'(DEPTH); n++) begin
      enq_data_i = DATA_W'($urandom);
      step();
    end
    #1;
    n_checks++;
    if (full_o !== 1'b1 || enq_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_flags full=%b enq_ready=%b required full=1 enq_ready=0", full_o, enq_ready_o);
    end
    deq_req_i = 1'b1;
    for (int n = 0; n < 10 && !got; n++) begin
      #1;
      if (enq_ready_o) bad = 1'b1;
      got = deq_ready_o;
      step();
    end
    deq_req_i = 1'b0; enq_valid_i = 1'b0;
    n_checks++;
    if (!got || bad) begin
      n_fail++; $display("FAIL full_deq deq_accepted=%b enq_ready_seen=%b required 1/0", got, bad);
    end
    n_checks++;
    if (count_o !== CW'(DEPTH - 1)) begin
      n_fail++; $display("FAIL full_count got=%0d required=%0d", count_o, DEPTH - 1);
    end
    repeat (ISSUE_GAP - 1) step();
    #1;
    n_checks++;
    if (enq_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL full_reenable enq_ready=%b required=1", enq_ready_o);
    end
  endtask

  task automatic test_tie();
    int   ord[$];
    logic both = 1'b0;
    enq_valid_i = 1'b1; deq_req_i = 1'b1;
    for (int n = 0; n < 40 && ord.size() < 4; n++) begin
      enq_data_i = DATA_W'($urandom);
      #1;
      if (enq_ready_o && deq_ready_o) both = 1'b1;
      if (deq_ready_o) ord.push_back(1);
      else if (enq_ready_o) ord.push_back(0);
      step();
    end
    enq_valid_i = 1'b0; deq_req_i = 1'b0;
    n_checks++;
    if (ord.size() != 4 || both) begin
      n_fail++; $display("FAIL tie_grants got=%0d both_ready=%b required 4 grants, never both", ord.size(), both);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ord[i] != ((i % 2 == 0) ? 1 : 0)) begin
          n_fail++; $display("FAIL tie_order[%0d] got=%s required=%s", i, ord[i] ? "DEQ" : "ENQ", (i % 2 == 0) ? "DEQ" : "ENQ");
        end
      end
    end
  endtask

  task automatic test_clear();
    int   rc = -1;
    logic got, seen = 1'b0;
    deq_req_i = 1'b1;
    for (int n = 0; n < 20 && rc < 0; n++) begin
      #1;
      if (read_o) rc = cyc;
      got = deq_req_i && deq_ready_o;
      step();
      if (got) deq_req_i = 1'b0;
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    #1;
    n_checks++;
    if (rc < 0 || reset_o !== 1'b1 || count_o !== '0 || empty_o !== 1'b1) begin
      n_fail++; $display("FAIL clear_flush read_seen=%0d reset_o=%b count=%0d empty=%b required 1/0/1", rc >= 0, reset_o, count_o, empty_o);
    end
    step(); #1;
    n_checks++;
    if (reset_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_pulse reset_o=%b required=0 after one cycle", reset_o);
    end
    for (int n = 0; n < RD_LAT + 3; n++) begin
      if (deq_valid_o) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL clear_kill deq_valid seen=1 required=0");
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] pend[$];
    for (int n = 0; n < 400; n++) begin
      enq_valid_i = ($urandom_range(1, 0) == 1);
      deq_req_i   = ($urandom_range(1, 0) == 1);
      clear_i     = ($urandom_range(39, 0) == 0);
      enq_data_i  = DATA_W'($urandom);
      #1;
      if (write_o) begin
        n_checks++;
        if (pend.size() == 0) begin
          n_fail++; $display("FAIL rand_write cyc=%0d unexpected write_o", cyc);
        end else if (wr_data_o !== pend[0]) begin
          n_fail++; $display("FAIL rand_wr_data cyc=%0d got=%0d required=%0d", cyc, wr_data_o, pend[0]);
        end
        if (pend.size() > 0) void'(pend.pop_front());
      end
      if (enq_valid_i && enq_ready_o) pend.push_back(enq_data_i);
      step();
    end
    enq_valid_i = 1'b0; deq_req_i = 1'b0; clear_i = 1'b0;
    repeat (RD_LAT + 3) step();
    n_checks++;
    if (ret_q.size() != 0 || pend.size() != 0) begin
      n_fail++; $display("FAIL rand_drain returns=%0d writes=%0d required 0/0", ret_q.size(), pend.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b1;
    test_reset();
    test_enq_b2b();
    test_deq();
    test_full();
    test_tie();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
